// File: rtl/modbus_pkg.sv
// Shared Modbus RTU constants: function codes, CRC-16 parameters, completion codes.
// Used by the master and the slave-side blocks.
package modbus_pkg;

   localparam logic [7:0]  FC_READ_HOLD    = 8'h03;
   localparam logic [7:0]  FC_WRITE_SINGLE = 8'h06;
   localparam logic [7:0]  EXC_BIT         = 8'h80;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'hA001;

   localparam logic [2:0]  ERR_OK        = 3'd0;
   localparam logic [2:0]  ERR_TIMEOUT   = 3'd1;
   localparam logic [2:0]  ERR_CRC       = 3'd2;
   localparam logic [2:0]  ERR_EXCEPTION = 3'd3;
   localparam logic [2:0]  ERR_MISMATCH  = 3'd4;
   localparam logic [2:0]  ERR_FRAMING   = 3'd5;
   localparam logic [2:0]  ERR_ILLEGAL   = 3'd6;

   typedef struct packed {
      logic        write;
      logic [7:0]  slave;
      logic [15:0] addr;
      logic [15:0] wdata;
   } req_t;

endpackage

// File: rtl/modbus_crc16.sv
// Combinational CRC-16/Modbus update: folds one whole byte into the running CRC.
// Reflected polynomial, LSB first, eight shift steps unrolled.
module modbus_crc16
   import modbus_pkg::*;
(
   input  logic [15:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);

   always_comb begin
      crc_o = crc_i ^ {8'h00, data_i};
      for (int k = 0; k < 8; k++) begin
         crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC_POLY) : (crc_o >> 1);
      end
   end

endmodule

// File: rtl/modbus_rtu_master.sv
// Modbus RTU master: one FC03/FC06 single-register transaction per request over a UART byte stream.
// Done is registered one clock after the deciding event; TX holds each byte until tx_ready.
module modbus_rtu_master
   import modbus_pkg::*;
#(
   parameter int GapCycles     = 4000,
   parameter int TimeoutCycles = 120000,
   parameter int CountW        = 17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [7:0]  req_slave,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        done,
   output logic [2:0]  err,
   output logic [15:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_ferr
);

   localparam logic [2:0] ST_GAP     = 3'd0;
   localparam logic [2:0] ST_IDLE    = 3'd1;
   localparam logic [2:0] ST_SEND    = 3'd2;
   localparam logic [2:0] ST_WAIT_RX = 3'd3;
   localparam logic [2:0] ST_RECV    = 3'd4;

   localparam logic [CountW-1:0] GAP_LAST = CountW'(GapCycles - 1);
   localparam logic [CountW-1:0] TMO_LAST = CountW'(TimeoutCycles - 1);

   // Bytes 0..5 of the request; the write echo must reproduce the same six bytes.
   function automatic logic [7:0] req_byte(input req_t r, input logic [2:0] i);
      logic [7:0] fc;
      fc = r.write ? FC_WRITE_SINGLE : FC_READ_HOLD;
      case (i)
         3'd0:    req_byte = r.slave;
         3'd1:    req_byte = fc;
         3'd2:    req_byte = r.addr[15:8];
         3'd3:    req_byte = r.addr[7:0];
         3'd4:    req_byte = r.write ? r.wdata[15:8] : 8'h00;
         3'd5:    req_byte = r.write ? r.wdata[7:0]  : 8'h01;
         default: req_byte = 8'h00;
      endcase
   endfunction

   logic [2:0]        state_q, state_d;
   logic [CountW-1:0] cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic [2:0]        tx_idx_q, tx_idx_d;
   logic [2:0]        rx_idx_q, rx_idx_d;
   logic [15:0]       crc_q, crc_d;
   logic              exc_q, exc_d;
   logic              ferr_q, ferr_d;
   logic              crc_bad_q, crc_bad_d;
   logic              mism_q, mism_d;
   logic [15:0]       rd_q, rd_d;
   logic              done_q, done_d;
   logic [2:0]        err_q, err_d;
   logic [15:0]       rdata_q, rdata_d;

   logic [7:0]  req_fc, tx_byte, crc_byte;
   logic [15:0] crc_next;
   logic        tx_hs, exc_now;
   logic [2:0]  rx_idx, last_idx;

   assign req_fc   = req_q.write ? FC_WRITE_SINGLE : FC_READ_HOLD;
   assign tx_byte  = (tx_idx_q == 3'd6) ? crc_q[7:0] :
                     (tx_idx_q == 3'd7) ? crc_q[15:8] : req_byte(req_q, tx_idx_q);
   assign tx_hs    = (state_q == ST_SEND) && tx_ready;
   assign crc_byte = (state_q == ST_SEND) ? tx_byte : rx_data;

   // The frame length is only known once byte 1 reveals whether it is an exception.
   assign rx_idx   = (state_q == ST_WAIT_RX) ? 3'd0 : rx_idx_q;
   assign exc_now  = (rx_idx == 3'd1) ? rx_data[7] : exc_q;
   assign last_idx = exc_now ? 3'd4 : (req_q.write ? 3'd7 : 3'd6);

   modbus_crc16 u_crc (
      .crc_i  (crc_q),
      .data_i (crc_byte),
      .crc_o  (crc_next)
   );

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      tx_idx_d  = tx_idx_q;
      rx_idx_d  = rx_idx_q;
      crc_d     = crc_q;
      exc_d     = exc_q;
      ferr_d    = ferr_q;
      crc_bad_d = crc_bad_q;
      mism_d    = mism_q;
      rd_d      = rd_q;
      done_d    = 1'b0;
      err_d     = err_q;
      rdata_d   = rdata_q;
      cnt_d     = (state_q == ST_GAP || state_q == ST_WAIT_RX || state_q == ST_RECV) ?
                  cnt_q + CountW'(1) : '0;
      if (rx_valid || tx_hs) cnt_d = '0;

      case (state_q)
         ST_GAP: begin
            if (!rx_valid && cnt_q == GAP_LAST) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (req_valid) begin
               req_d.write = req_write;
               req_d.slave = req_slave;
               req_d.addr  = req_addr;
               req_d.wdata = req_wdata;
               if (!req_write && req_slave == 8'h00) begin
                  done_d  = 1'b1;
                  err_d   = ERR_ILLEGAL;
                  state_d = ST_GAP;
               end else begin
                  tx_idx_d = 3'd0;
                  crc_d    = CRC_INIT;
                  state_d  = ST_SEND;
               end
            end else if (rx_valid) begin
               state_d = ST_GAP;
            end
         end
         ST_SEND: begin
            if (tx_ready) begin
               if (tx_idx_q < 3'd6) crc_d = crc_next;
               tx_idx_d = tx_idx_q + 3'd1;
               if (tx_idx_q == 3'd7) begin
                  crc_d     = CRC_INIT;
                  rx_idx_d  = 3'd0;
                  exc_d     = 1'b0;
                  ferr_d    = 1'b0;
                  crc_bad_d = 1'b0;
                  mism_d    = 1'b0;
                  if (req_q.slave == 8'h00) begin
                     done_d  = 1'b1;
                     err_d   = ERR_OK;
                     state_d = ST_GAP;
                  end else begin
                     state_d = ST_WAIT_RX;
                  end
               end
            end
         end
         ST_WAIT_RX, ST_RECV: begin
            if (rx_valid) begin
               ferr_d = ferr_q | rx_ferr;
               exc_d  = exc_now;
               if (rx_idx < last_idx - 3'd1) crc_d = crc_next;
               if (rx_idx == last_idx - 3'd1 && rx_data != crc_q[7:0])  crc_bad_d = 1'b1;
               if (rx_idx == last_idx && rx_data != crc_q[15:8])        crc_bad_d = 1'b1;
               case (rx_idx)
                  3'd0: if (rx_data != req_q.slave) mism_d = 1'b1;
                  3'd1: if (rx_data != req_fc && rx_data != (req_fc | EXC_BIT)) mism_d = 1'b1;
                  3'd2: begin
                     if (exc_now) rd_d = {8'h00, rx_data};
                     else if (rx_data != (req_q.write ? req_byte(req_q, 3'd2) : 8'h02)) mism_d = 1'b1;
                  end
                  default: begin
                     if (req_q.write && !exc_now && rx_idx <= 3'd5 &&
                         rx_data != req_byte(req_q, rx_idx)) mism_d = 1'b1;
                     if (!req_q.write && !exc_now && rx_idx == 3'd3) rd_d[15:8] = rx_data;
                     if (!req_q.write && !exc_now && rx_idx == 3'd4) rd_d[7:0]  = rx_data;
                  end
               endcase
               rx_idx_d = rx_idx + 3'd1;
               state_d  = ST_RECV;
               if (rx_idx == last_idx) begin
                  done_d  = 1'b1;
                  state_d = ST_GAP;
                  if (ferr_d)         err_d = ERR_FRAMING;
                  else if (crc_bad_d) err_d = ERR_CRC;
                  else if (mism_d)    err_d = ERR_MISMATCH;
                  else if (exc_now)   err_d = ERR_EXCEPTION;
                  else                err_d = ERR_OK;
                  if ((err_d == ERR_OK && !req_q.write) || err_d == ERR_EXCEPTION) rdata_d = rd_q;
               end
            end else if (state_q == ST_WAIT_RX && cnt_q == TMO_LAST) begin
               done_d  = 1'b1;
               err_d   = ERR_TIMEOUT;
               cnt_d   = '0;
               state_d = ST_GAP;
            end else if (state_q == ST_RECV && cnt_q == GAP_LAST) begin
               done_d  = 1'b1;
               err_d   = ERR_MISMATCH;
               cnt_d   = '0;
               state_d = ST_GAP;
            end
         end
         default: state_d = ST_GAP;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_GAP;
         cnt_q     <= '0;
         req_q     <= '0;
         tx_idx_q  <= 3'd0;
         rx_idx_q  <= 3'd0;
         crc_q     <= CRC_INIT;
         exc_q     <= 1'b0;
         ferr_q    <= 1'b0;
         crc_bad_q <= 1'b0;
         mism_q    <= 1'b0;
         rd_q      <= 16'h0000;
         done_q    <= 1'b0;
         err_q     <= ERR_OK;
         rdata_q   <= 16'h0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         tx_idx_q  <= tx_idx_d;
         rx_idx_q  <= rx_idx_d;
         crc_q     <= crc_d;
         exc_q     <= exc_d;
         ferr_q    <= ferr_d;
         crc_bad_q <= crc_bad_d;
         mism_q    <= mism_d;
         rd_q      <= rd_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign tx_valid  = (state_q == ST_SEND);
   assign tx_data   = tx_valid ? tx_byte : 8'h00;
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_modbus_rtu_master.sv
// Directed bench for modbus_rtu_master with shortened gap/timeout so it finishes quickly.
module tb_modbus_rtu_master;

   localparam int G = 40;
   localparam int T = 300;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [7:0]  req_slave = 8'h00;
   logic [15:0] req_addr = 16'h0000;
   logic [15:0] req_wdata = 16'h0000;
   logic        done;
   logic [2:0]  err;
   logic [15:0] rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ferr = 1'b0;

   always #5 clk = ~clk;

   modbus_rtu_master #(.GapCycles(G), .TimeoutCycles(T), .CountW(17)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_slave(req_slave), .req_addr(req_addr), .req_wdata(req_wdata),
      .done(done), .err(err), .rdata(rdata),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] txe [8];
   logic [7:0] rxe [8];
   int rxn;

   function automatic logic [15:0] crc16(input logic [7:0] b [8], input int n);
      logic [15:0] c;
      logic fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[i][k];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
         end
      end
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_req(input logic w, input logic [7:0] s, input logic [15:0] a, input logic [15:0] d);
      int n;
      n = 0;
      while (!req_ready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) chk("req_ready_wait", 32'd0, 32'd1);
      req_valid = 1'b1; req_write = w; req_slave = s; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic expect_tx(input int stall_at);
      for (int i = 0; i < 8; i++) begin
         int w;
         w = 0;
         while (!tx_valid && w < 50) begin @(negedge clk); w++; end
         chk($sformatf("tx_byte%0d", i), {24'h0, tx_data}, {24'h0, txe[i]});
         if (i == stall_at) begin
            logic ok;
            ok = 1'b1;
            tx_ready = 1'b0;
            repeat (50) begin
               @(negedge clk);
               if (!(tx_valid === 1'b1 && tx_data === txe[i])) ok = 1'b0;
            end
            chk("stall_stable", {31'h0, ok}, 32'd1);
            tx_ready = 1'b1;
         end
         @(negedge clk);
      end
   endtask

   task automatic send_rx(input int ferr_at);
      for (int i = 0; i < rxn; i++) begin
         rx_valid = 1'b1; rx_data = rxe[i]; rx_ferr = (i == ferr_at);
         @(negedge clk);
         rx_valid = 1'b0; rx_ferr = 1'b0;
         if (i < rxn - 1) @(negedge clk);
      end
   endtask

   task automatic check_done(input string tag, input logic [2:0] e, input logic [15:0] rd);
      chk({tag, "_done"}, {31'h0, done}, 32'd1);
      chk({tag, "_err"}, {29'h0, err}, {29'h0, e});
      chk({tag, "_rdata"}, {16'h0, rdata}, {16'h0, rd});
   endtask

   initial begin
      logic early;
      logic [15:0] c;

      // Reset state and power-up gap
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
      chk("rst_outputs", {done, err, rdata, tx_data}, 32'd0);
      reset = 1'b0;
      repeat (G - 1) @(negedge clk);
      chk("gap_not_ready", {31'h0, req_ready}, 32'd0);
      @(negedge clk);
      chk("gap_ready", {31'h0, req_ready}, 32'd1);

      // 1: read, slave 1, addr 0
      send_req(1'b0, 8'h01, 16'h0000, 16'h0000);
      txe = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
      expect_tx(-1);
      rxe = '{8'h01, 8'h03, 8'h02, 8'h12, 8'h34, 8'hB5, 8'h33, 8'h00}; rxn = 7;
      send_rx(-1);
      check_done("read_ok", 3'd0, 16'h1234);
      @(negedge clk);
      chk("done_pulse", {31'h0, done}, 32'd0);

      // 2: write echo, then echo with wrong data byte
      send_req(1'b1, 8'h01, 16'h0001, 16'h0003);
      txe = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
      expect_tx(-1);
      rxe = txe; rxn = 8;
      send_rx(-1);
      check_done("write_ok", 3'd0, 16'h1234);
      send_req(1'b1, 8'h01, 16'h0001, 16'h0003);
      expect_tx(-1);
      rxe = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00};
      c = crc16(rxe, 6); rxe[6] = c[7:0]; rxe[7] = c[15:8];
      send_rx(-1);
      check_done("write_mism", 3'd4, 16'h1234);

      // 3: no response -> timeout exactly T clocks after last handshake
      send_req(1'b0, 8'h01, 16'h0000, 16'h0000);
      txe = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
      expect_tx(-1);
      early = 1'b0;
      repeat (T - 1) begin @(negedge clk); if (done) early = 1'b1; end
      chk("tmo_no_early", {31'h0, early}, 32'd0);
      @(negedge clk);
      check_done("timeout", 3'd1, 16'h1234);
      repeat (G - 1) @(negedge clk);
      chk("tmo_gap_not_ready", {31'h0, req_ready}, 32'd0);
      @(negedge clk);
      chk("tmo_gap_ready", {31'h0, req_ready}, 32'd1);

      // 4: corrupted CRC, then exception response
      send_req(1'b0, 8'h01, 16'h0000, 16'h0000);
      expect_tx(-1);
      rxe = '{8'h01, 8'h03, 8'h02, 8'h12, 8'h34, 8'hB5, 8'h34, 8'h00}; rxn = 7;
      send_rx(-1);
      check_done("crc_err", 3'd2, 16'h1234);
      send_req(1'b0, 8'h01, 16'h0000, 16'h0000);
      expect_tx(-1);
      rxe = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1, 8'h00, 8'h00, 8'h00}; rxn = 5;
      send_rx(-1);
      check_done("exception", 3'd3, 16'h0002);

      // Framing error outranks everything; rdata held
      send_req(1'b0, 8'h01, 16'h0000, 16'h0000);
      expect_tx(-1);
      rxe = '{8'h01, 8'h03, 8'h02, 8'h12, 8'h34, 8'hB5, 8'h33, 8'h00}; rxn = 7;
      send_rx(3);
      check_done("ferr", 3'd5, 16'h0002);

      // 5: broadcast write completes at last handshake; broadcast read is illegal
      send_req(1'b1, 8'h00, 16'h0001, 16'h0003);
      txe = '{8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00};
      c = crc16(txe, 6); txe[6] = c[7:0]; txe[7] = c[15:8];
      expect_tx(-1);
      check_done("bcast_write", 3'd0, 16'h0002);
      send_req(1'b0, 8'h00, 16'h0000, 16'h0000);
      chk("bcast_read_no_tx", {31'h0, tx_valid}, 32'd0);
      check_done("bcast_read", 3'd6, 16'h0002);
      @(negedge clk);
      chk("bcast_read_no_tx2", {31'h0, tx_valid}, 32'd0);

      // 6: stalled TX, then reset in the middle of the response
      send_req(1'b0, 8'h01, 16'h0000, 16'h0000);
      txe = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
      expect_tx(3);
      rxe = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; rxn = 3;
      send_rx(-1);
      reset = 1'b1;
      #1;
      chk("mid_rst_req_ready", {31'h0, req_ready}, 32'd0);
      chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'd0);
      chk("mid_rst_outputs", {done, err, rdata, tx_data}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rxe = '{8'h12, 8'h34, 8'hB5, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00}; rxn = 4;
      send_rx(-1);
      early = 1'b0;
      repeat (G + 20) begin @(negedge clk); if (done) early = 1'b1; end
      chk("mid_rst_no_done", {31'h0, early}, 32'd0);
      chk("mid_rst_ready_again", {31'h0, req_ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
